// File: rtl/radix2_pkg.sv
// Shared definitions for the radix-2 multiplier and divider datapath blocks.
// Latency: none (package only).
// Backpressure: none (package only).
package radix2_pkg;

    // Default operand width used by both arithmetic blocks
    localparam int DEFAULT_WIDTH = 8;

    // FSM state encoding shared by the multiplier and divider
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Iteration counter width: enough bits to count WIDTH iterations (min 1)
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/radix2_abs.sv
// Conditional two's-complement negate: out = neg_en ? -in : in.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module radix2_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] in,
    input  logic         neg_en,
    output logic [W-1:0] out
);

    // The most negative input maps to 2^(W-1), which the caller reads as unsigned
    assign out = neg_en ? (~in + W'(1)) : in;

endmodule

// File: rtl/radix2_mul.sv
// Sequential radix-2 shift-add multiplier, signed or unsigned, one product bit per clock.
// Latency: accept at edge k -> res_valid high after edge k+WIDTH.
// Backpressure: opn_ready only in IDLE; product held in DONE until res_ready.
module radix2_mul
    import radix2_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sign,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 opn_valid,
    output logic                 opn_ready,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   result
);

    localparam int CW = cnt_width(WIDTH);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH:0]     acc_q, acc_d;      // {carry, high, low}
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     iter_acc;
    logic [2*WIDTH-1:0]   prod_fixed;

    // Operand magnitudes are only taken for signed operations
    radix2_abs #(.W(WIDTH)) u_abs_a (
        .in     (multiplicand),
        .neg_en (sign & multiplicand[WIDTH-1]),
        .out    (a_mag)
    );

    radix2_abs #(.W(WIDTH)) u_abs_b (
        .in     (multiplier),
        .neg_en (sign & multiplier[WIDTH-1]),
        .out    (b_mag)
    );

    // One shift-add step: conditional add into the high half, then shift right
    assign sum      = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
    assign iter_acc = acc_q[0] ? ({sum, acc_q[WIDTH-1:0]} >> 1) : (acc_q >> 1);

    // Sign fix of the final product, applied on the last iteration so it lands in result_q
    radix2_abs #(.W(2*WIDTH)) u_abs_p (
        .in     (iter_acc[2*WIDTH-1:0]),
        .neg_en (neg_q),
        .out    (prod_fixed)
    );

    // Next-state logic for the FSM and the datapath registers
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (opn_valid) begin
                    state_d = BUSY;
                    mcand_d = a_mag;
                    acc_d   = {{(WIDTH+1){1'b0}}, b_mag};
                    cnt_d   = '0;
                    neg_d   = sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
                end
            end
            BUSY: begin
                acc_d = iter_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = DONE;
                    result_d = prod_fixed;
                end
            end
            DONE: begin
                // A concurrent opn_valid is not accepted here; IDLE takes it next edge
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset discards any running operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    // Handshake outputs are pure decodes of the registered state
    assign opn_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign result    = result_q;

endmodule
